// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time memory loader.
// Optional feature macro: MEM_LOADER_CHECKSUM_EN (adds the CHK state).
package mem_loader_pkg;

  // Header fields (base address, payload length) are each this many bytes.
  localparam int HDR_BYTES = 4;

  // Byte lane inside a 32-bit word; also reused as the header byte counter.
  typedef logic [1:0] lane_t;

  // Loader state encoding, fixed values so the encoding is stable across builds.
  typedef enum logic [2:0] {
    HDR_ADDR = 3'd0,
    HDR_LEN  = 3'd1,
    PAYLOAD  = 3'd2,
    WRITE    = 3'd3,
`ifdef MEM_LOADER_CHECKSUM_EN
    CHK      = 3'd4,
`endif
    DONE     = 3'd5,
    ERR      = 3'd6
  } state_e;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Packs little-endian bytes into a 32-bit word and tracks which lanes
// have been filled. clear_i has priority over push_i.
module byte_packer
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        clear_i,
  input  lane_t       lane_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [3:0]  byte_en_o
);

  logic [31:0] word_q, word_d;
  logic [3:0]  be_q, be_d;

  // Next-state: drop the byte into its lane, or empty the word after a write.
  always_comb begin
    word_d = word_q;
    be_d   = be_q;
    if (clear_i) begin
      word_d = '0;
      be_d   = '0;
    end else if (push_i) begin
      word_d[{lane_i, 3'b000} +: 8] = byte_i;
      be_d[lane_i]                  = 1'b1;
    end
  end

  // Packing registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      word_q <= '0;
      be_q   <= '0;
    end else begin
      word_q <= word_d;
      be_q   <= be_d;
    end
  end

  assign word_o    = word_q;
  assign byte_en_o = be_q;

endmodule

// File: rtl/mem_loader.sv
// Boot-time program loader: parses a framed little-endian byte stream
// (base address, length, payload), writes packed words to memory and holds
// the core until the image is complete.
// Optional feature macro: MEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int MAX_LEN_BYTES    = 1024,
  parameter int BASE_ALIGN_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_en,
  output logic [3:0]  mem_byte_en,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] ALIGN_MASK = 32'(BASE_ALIGN_BYTES - 1);
  localparam logic [31:0] MAX_LEN    = 32'(MAX_LEN_BYTES);
  localparam lane_t       HDR_LAST   = lane_t'(HDR_BYTES - 1);

`ifdef MEM_LOADER_CHECKSUM_EN
  localparam state_e END_STATE = CHK;
`else
  localparam state_e END_STATE = DONE;
`endif

  state_e      state_q, state_d;
  lane_t       cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] base_q, base_d;
  logic [31:0] remain_q, remain_d;
  logic [29:0] widx_q, widx_d;
  logic        run_q;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  logic        readyInt;
  logic        accept;
  logic [31:0] hdrWord;
  logic [31:0] packWord;
  logic [3:0]  packBe;

  // run_q keeps in_ready low on the cycle right after reset, so every
  // output is a pure decode of registers.
  assign readyInt = run_q && ((state_q == HDR_ADDR) || (state_q == HDR_LEN) ||
`ifdef MEM_LOADER_CHECKSUM_EN
                              (state_q == CHK) ||
`endif
                              (state_q == PAYLOAD));
  assign accept   = in_valid && readyInt;
  assign hdrWord  = {in_data, shift_q};

  byte_packer u_packer (
    .clk       (clk),
    .rst_ni    (rst),
    .push_i    (accept && (state_q == PAYLOAD)),
    .clear_i   (state_q == WRITE),
    .lane_i    (cnt_q),
    .byte_i    (in_data),
    .word_o    (packWord),
    .byte_en_o (packBe)
  );

  // Frame parser and write sequencer next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    base_d   = base_q;
    remain_d = remain_q;
    widx_d   = widx_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    xor_d    = xor_q;
`endif
    case (state_q)
      HDR_ADDR: begin
        if (accept) begin
          shift_d = hdrWord[31:8];
          cnt_d   = lane_t'(cnt_q + 2'd1);
          if (cnt_q == HDR_LAST) begin
            base_d  = hdrWord;
            state_d = ((hdrWord & ALIGN_MASK) != 32'd0) ? ERR : HDR_LEN;
          end
        end
      end
      HDR_LEN: begin
        if (accept) begin
          shift_d = hdrWord[31:8];
          cnt_d   = lane_t'(cnt_q + 2'd1);
          if (cnt_q == HDR_LAST) begin
            remain_d = hdrWord;
            widx_d   = '0;
            if (hdrWord > MAX_LEN)       state_d = ERR;
            else if (hdrWord == 32'd0)   state_d = END_STATE;
            else                         state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          remain_d = remain_q - 32'd1;
          cnt_d    = lane_t'(cnt_q + 2'd1);
`ifdef MEM_LOADER_CHECKSUM_EN
          xor_d    = xor_q ^ in_data;
`endif
          if ((cnt_q == 2'd3) || (remain_q == 32'd1)) state_d = WRITE;
        end
      end
      WRITE: begin
        widx_d  = widx_q + 30'd1;
        cnt_d   = '0;
        state_d = (remain_q != 32'd0) ? PAYLOAD : END_STATE;
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) state_d = (in_data == xor_q) ? DONE : ERR;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= HDR_ADDR;
      cnt_q    <= '0;
      shift_q  <= '0;
      base_q   <= '0;
      remain_q <= '0;
      widx_q   <= '0;
      run_q    <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      base_q   <= base_d;
      remain_q <= remain_d;
      widx_q   <= widx_d;
      run_q    <= 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  // Memory port is only non-zero during the single WRITE cycle.
  assign mem_wr_en   = (state_q == WRITE);
  assign mem_addr    = mem_wr_en ? (base_q + {widx_q, 2'b00}) : 32'd0;
  assign mem_wr_data = mem_wr_en ? packWord : 32'd0;
  assign mem_byte_en = mem_wr_en ? packBe : 4'd0;
  assign in_ready    = readyInt;
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERR);
  assign cpu_hold    = (state_q != DONE);

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table of frames plus hand-written
// reset-abort and checksum sequences; writes are checked by a scoreboard.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_en;
  logic [3:0]  mem_byte_en;
  logic        cpu_hold;
  logic        done;
  logic        error;

  mem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_byte_en (mem_byte_en),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] len;
    int          hdrBytes;
    logic [7:0]  first;
    logic [7:0]  step;
    bit          gaps;
    logic [7:0]  chkFlip;
    bit          expDone;
    bit          expErr;
    int          expWrites;
  } vec_t;

  wr_t  expQ[$];
  vec_t vecs[$];
  wr_t  monE;
  int   checkCount = 0;
  int   passCount  = 0;
  int   writeCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Scoreboard: every write strobe pops one expected write and compares it.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      writeCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected write addr", mem_addr, 32'hFFFF_FFFF);
      end else begin
        monE = expQ.pop_front();
        checkOutput("wr addr", mem_addr, monE.addr);
        checkOutput("wr data", mem_wr_data, monE.data);
        checkOutput("wr byte_en", 32'(mem_byte_en), 32'(monE.be));
      end
      checkOutput("done during write", 32'(done), 32'd0);
    end
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] byteAt(input vec_t v, input int i);
    return 8'(int'(v.first) + i * int'(v.step));
  endfunction

  function automatic void addVec(input logic [31:0] base, input logic [31:0] len,
                                 input int hdrBytes, input logic [7:0] first,
                                 input logic [7:0] step, input bit gaps,
                                 input logic [7:0] chkFlip, input bit expDone,
                                 input bit expErr, input int expWrites);
    vec_t v;
    v.base = base; v.len = len; v.hdrBytes = hdrBytes; v.first = first;
    v.step = step; v.gaps = gaps; v.chkFlip = chkFlip; v.expDone = expDone;
    v.expErr = expErr; v.expWrites = expWrites;
    vecs.push_back(v);
  endfunction

  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int waitCycles;
    if (gaps) begin
      int g = int'($urandom_range(0, 3));
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waitCycles = 0;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("handshake timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("rst addr", mem_addr, 32'd0);
    checkOutput("rst data", mem_wr_data, 32'd0);
    checkOutput("rst byte_en", 32'(mem_byte_en), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst error", 32'(error), 32'd0);
    checkOutput("rst cpu_hold", 32'(cpu_hold), 32'd1);
    expQ.delete();
    writeCount = 0;
    rst = 1'b1;
  endtask

  // Push the expected writes for a frame, then drive header, payload and checksum.
  task automatic applyStimulus(input vec_t v);
    logic [63:0] hdr;
    logic [7:0]  xorAcc;
    bit          payloadSent;
    wr_t         e;
    hdr = {v.len, v.base};
    xorAcc = 8'h00;
    payloadSent = (v.hdrBytes == 8) && (v.len <= 32'd1024);
    if (payloadSent) begin
      for (int w = 0; w * 4 < int'(v.len); w++) begin
        e.addr = v.base + 32'(4 * w);
        e.data = '0;
        e.be   = '0;
        for (int l = 0; l < 4; l++) begin
          if (w * 4 + l < int'(v.len)) begin
            e.data[8*l +: 8] = byteAt(v, w * 4 + l);
            e.be[l] = 1'b1;
          end
        end
        expQ.push_back(e);
      end
    end
    for (int k = 0; k < v.hdrBytes; k++) sendByte(hdr[8*k +: 8], v.gaps);
    if (payloadSent) begin
      for (int i = 0; i < int'(v.len); i++) begin
        sendByte(byteAt(v, i), v.gaps);
        xorAcc = xorAcc ^ byteAt(v, i);
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      sendByte(xorAcc ^ v.chkFlip, v.gaps);
`endif
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input bit expDone, input bit expErr,
                            input int expWrites);
    int n = 0;
    while (!(done || error) && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput({tag, " done"}, 32'(done), 32'(expDone));
    checkOutput({tag, " error"}, 32'(error), 32'(expErr));
    checkOutput({tag, " cpu_hold"}, 32'(cpu_hold), 32'(!expDone));
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, " write count"}, 32'(writeCount), 32'(expWrites));
    checkOutput({tag, " pending writes"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    // base, len, hdrBytes, first, step, gaps, chkFlip, expDone, expErr, expWrites
    addVec(32'h0000_0100, 32'd8,    8, 8'h11, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 2);
    addVec(32'h0000_0100, 32'd5,    8, 8'h11, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 2);
    addVec(32'h0000_0102, 32'd0,    4, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 0);
    addVec(32'h0000_0101, 32'd0,    4, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 0);
    addVec(32'h0000_0100, 32'd0,    8, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    addVec(32'h0000_0100, 32'd1025, 8, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 0);
    addVec(32'h0000_0100, 32'd8,    8, 8'h11, 8'h11, 1'b1, 8'h00, 1'b1, 1'b0, 2);
    addVec(32'hFFFF_FFF8, 32'd12,   8, 8'h01, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 3);
    addVec(32'h0000_0104, 32'd7,    8, 8'hA0, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 2);
    addVec(32'h0000_2000, 32'd1024, 8, 8'h00, 8'h03, 1'b0, 8'h00, 1'b1, 1'b0, 256);
`ifdef MEM_LOADER_CHECKSUM_EN
    addVec(32'h0000_0100, 32'd0,    8, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, 0);
    addVec(32'h0000_0100, 32'd4,    8, 8'h01, 8'h01, 1'b0, 8'h40, 1'b0, 1'b1, 1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      doReset();
      applyStimulus(vecs[i]);
      checkFrame($sformatf("vec%0d", i), vecs[i].expDone, vecs[i].expErr,
                 vecs[i].expWrites);
    end

    // Abort a frame with reset while the third payload byte is on the bus,
    // then load a fresh frame and make sure nothing stale leaks into it.
    begin
      vec_t abortV;
      vec_t freshV;
      logic [63:0] hdr;
      doReset();
      hdr = {32'd8, 32'h0000_0100};
      for (int k = 0; k < 8; k++) sendByte(hdr[8*k +: 8], 1'b0);
      sendByte(8'h11, 1'b0);
      sendByte(8'h22, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h33;
      rst      = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("abort in_ready", 32'(in_ready), 32'd0);
      checkOutput("abort wr_en", 32'(mem_wr_en), 32'd0);
      checkOutput("abort cpu_hold", 32'(cpu_hold), 32'd1);
      checkOutput("abort write count", 32'(writeCount), 32'd0);
      in_valid = 1'b0;
      rst      = 1'b1;
      abortV = '{default: '0};
      freshV = abortV;
      freshV.base = 32'h0; freshV.len = 32'd4; freshV.hdrBytes = 8;
      freshV.first = 8'hAA; freshV.step = 8'h11;
      applyStimulus(freshV);
      checkFrame("fresh", 1'b1, 1'b0, 1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
